// File: rtl/hawk_cpu_req_gate.sv
// hacd_pkg: request/override packet types exchanged with hawk_ctrl_unit.
//
// hawk_cpu_req_gate: holds each CPU AXI AR/AW request until the control unit
// grants it, then issues it to memory with the page number replaced by the
// returned ppa. Write data is held back until its translated AW has been
// accepted by memory, and only one write burst is in flight at a time.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   s_ar_*, s_aw_*, s_w_*          CPU-side AXI AR/AW/W (slave)
//   m_ar_*, m_aw_*, m_w_*          memory-side AXI AR/AW/W (master)
//   cpu_rd_reqpkt, cpu_wr_reqpkt   {valid, hppa} published to the control unit
//   hawk_cpu_ovrd_rdpkt/_wrpkt     {allow_access, ppa} grants from the control unit
//   tmo_err                        sticky translation-timeout flag
//
// Optional feature: define HAWK_REQ_TIMEOUT_EN to enable a per-channel
// translation timeout. After TIMEOUT_CYC cycles in REQ the request is issued
// with an identity translation (ppa = hppa) and tmo_err is set.
// Without the macro, REQ waits indefinitely and tmo_err is tied to 0.

package hacd_pkg;
  localparam int unsigned HPPA_W = 52;

  typedef struct packed {
    logic              valid;
    logic [HPPA_W-1:0] hppa;
  } cpu_reqpkt_t;

  typedef struct packed {
    logic              allow_access;
    logic [HPPA_W-1:0] ppa;
  } hawk_cpu_ovrd_pkt_t;
endpackage

module hawk_cpu_req_gate
  import hacd_pkg::*;
#(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned PG_OFF_W    = 12,
  parameter int unsigned ID_W        = 4,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  // CPU-side AR
  input  logic               s_ar_valid,
  output logic               s_ar_ready,
  input  logic [ADDR_W-1:0]  s_ar_addr,
  input  logic [ID_W-1:0]    s_ar_id,
  input  logic [7:0]         s_ar_len,
  // CPU-side AW
  input  logic               s_aw_valid,
  output logic               s_aw_ready,
  input  logic [ADDR_W-1:0]  s_aw_addr,
  input  logic [ID_W-1:0]    s_aw_id,
  input  logic [7:0]         s_aw_len,
  // CPU-side W
  input  logic               s_w_valid,
  output logic               s_w_ready,
  input  logic [DATA_W-1:0]  s_w_data,
  input  logic               s_w_last,
  // Memory-side AR
  output logic               m_ar_valid,
  input  logic               m_ar_ready,
  output logic [ADDR_W-1:0]  m_ar_addr,
  output logic [ID_W-1:0]    m_ar_id,
  output logic [7:0]         m_ar_len,
  // Memory-side AW
  output logic               m_aw_valid,
  input  logic               m_aw_ready,
  output logic [ADDR_W-1:0]  m_aw_addr,
  output logic [ID_W-1:0]    m_aw_id,
  output logic [7:0]         m_aw_len,
  // Memory-side W
  output logic               m_w_valid,
  input  logic               m_w_ready,
  output logic [DATA_W-1:0]  m_w_data,
  output logic               m_w_last,
  // Control unit
  output cpu_reqpkt_t        cpu_rd_reqpkt,
  output cpu_reqpkt_t        cpu_wr_reqpkt,
  input  hawk_cpu_ovrd_pkt_t hawk_cpu_ovrd_rdpkt,
  input  hawk_cpu_ovrd_pkt_t hawk_cpu_ovrd_wrpkt,
  output logic               tmo_err
);

  localparam int unsigned PPA_W = ADDR_W - PG_OFF_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ISSUE
  } ch_state_e;

  ch_state_e             rd_state, wr_state;
  logic [PG_OFF_W-1:0]   rd_off, wr_off;
  logic [ID_W-1:0]       rd_id, wr_id;
  logic [7:0]            rd_len, wr_len;
  logic                  rd_tmo_hit, wr_tmo_hit;
  logic [PPA_W-1:0]      rd_ppa_sel, wr_ppa_sel;

  logic                  wr_open, wr_open_nxt;
  logic [7:0]            wr_cnt, wr_cnt_nxt;
  logic                  aw_fire, w_fire;

  // A timeout falls back to identity translation.
  assign rd_ppa_sel = hawk_cpu_ovrd_rdpkt.allow_access ? hawk_cpu_ovrd_rdpkt.ppa
                                                       : cpu_rd_reqpkt.hppa;
  assign wr_ppa_sel = hawk_cpu_ovrd_wrpkt.allow_access ? hawk_cpu_ovrd_wrpkt.ppa
                                                       : cpu_wr_reqpkt.hppa;

  // ---------------------------------------------------------------- read FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_state      <= ST_IDLE;
      rd_off        <= '0;
      rd_id         <= '0;
      rd_len        <= '0;
      s_ar_ready    <= 1'b1;
      cpu_rd_reqpkt <= '0;
      m_ar_valid    <= 1'b0;
      m_ar_addr     <= '0;
      m_ar_id       <= '0;
      m_ar_len      <= '0;
    end else begin
      case (rd_state)
        ST_IDLE: if (s_ar_valid && s_ar_ready) begin
          rd_off             <= s_ar_addr[PG_OFF_W-1:0];
          rd_id              <= s_ar_id;
          rd_len             <= s_ar_len;
          cpu_rd_reqpkt.valid <= 1'b1;
          cpu_rd_reqpkt.hppa  <= s_ar_addr[ADDR_W-1:PG_OFF_W];
          s_ar_ready         <= 1'b0;
          rd_state           <= ST_REQ;
        end
        ST_REQ: if (hawk_cpu_ovrd_rdpkt.allow_access || rd_tmo_hit) begin
          cpu_rd_reqpkt <= '0;
          m_ar_valid    <= 1'b1;
          m_ar_addr     <= {rd_ppa_sel, rd_off};
          m_ar_id       <= rd_id;
          m_ar_len      <= rd_len;
          rd_state      <= ST_ISSUE;
        end
        ST_ISSUE: if (m_ar_ready) begin
          m_ar_valid <= 1'b0;
          s_ar_ready <= 1'b1;
          rd_state   <= ST_IDLE;
        end
        default: rd_state <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------- write FSM
  // s_aw_ready is registered from the next-cycle wr_open so a new AW is never
  // offered while a burst's data is still flowing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state      <= ST_IDLE;
      wr_off        <= '0;
      wr_id         <= '0;
      wr_len        <= '0;
      s_aw_ready    <= 1'b1;
      cpu_wr_reqpkt <= '0;
      m_aw_valid    <= 1'b0;
      m_aw_addr     <= '0;
      m_aw_id       <= '0;
      m_aw_len      <= '0;
    end else begin
      case (wr_state)
        ST_IDLE: begin
          if (s_aw_valid && s_aw_ready) begin
            wr_off              <= s_aw_addr[PG_OFF_W-1:0];
            wr_id               <= s_aw_id;
            wr_len              <= s_aw_len;
            cpu_wr_reqpkt.valid <= 1'b1;
            cpu_wr_reqpkt.hppa  <= s_aw_addr[ADDR_W-1:PG_OFF_W];
            s_aw_ready          <= 1'b0;
            wr_state            <= ST_REQ;
          end else begin
            s_aw_ready <= !wr_open_nxt;
          end
        end
        ST_REQ: if (hawk_cpu_ovrd_wrpkt.allow_access || wr_tmo_hit) begin
          cpu_wr_reqpkt <= '0;
          m_aw_valid    <= 1'b1;
          m_aw_addr     <= {wr_ppa_sel, wr_off};
          m_aw_id       <= wr_id;
          m_aw_len      <= wr_len;
          wr_state      <= ST_ISSUE;
        end
        ST_ISSUE: if (m_aw_ready) begin
          m_aw_valid <= 1'b0;
          s_aw_ready <= 1'b0;
          wr_state   <= ST_IDLE;
        end
        default: wr_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- W gating
  assign aw_fire = m_aw_valid && m_aw_ready;
  assign w_fire  = wr_open && s_w_valid && m_w_ready;

  always_comb begin
    wr_open_nxt = wr_open;
    wr_cnt_nxt  = wr_cnt;
    if (w_fire) begin
      if (wr_cnt == '0 || s_w_last) begin
        wr_open_nxt = 1'b0;
        wr_cnt_nxt  = '0;
      end else begin
        wr_cnt_nxt = wr_cnt - 8'd1;
      end
    end
    if (aw_fire) begin
      wr_open_nxt = 1'b1;
      wr_cnt_nxt  = m_aw_len;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_open <= 1'b0;
      wr_cnt  <= '0;
    end else begin
      wr_open <= wr_open_nxt;
      wr_cnt  <= wr_cnt_nxt;
    end
  end

  assign m_w_valid = wr_open && s_w_valid;
  assign s_w_ready = wr_open && m_w_ready;
  assign m_w_data  = s_w_data;
  assign m_w_last  = s_w_last;

  // ------------------------------------------------------ translation timeout
`ifdef HAWK_REQ_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] rd_tmo_cnt, wr_tmo_cnt;

  // A grant in the same cycle wins; the timeout only fires when none arrives.
  assign rd_tmo_hit = (rd_state == ST_REQ) && !hawk_cpu_ovrd_rdpkt.allow_access &&
                      (rd_tmo_cnt == TMO_LAST);
  assign wr_tmo_hit = (wr_state == ST_REQ) && !hawk_cpu_ovrd_wrpkt.allow_access &&
                      (wr_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_tmo_cnt <= '0;
      wr_tmo_cnt <= '0;
      tmo_err    <= 1'b0;
    end else begin
      if (rd_state == ST_REQ && !hawk_cpu_ovrd_rdpkt.allow_access && !rd_tmo_hit)
        rd_tmo_cnt <= rd_tmo_cnt + 1'b1;
      else
        rd_tmo_cnt <= '0;
      if (wr_state == ST_REQ && !hawk_cpu_ovrd_wrpkt.allow_access && !wr_tmo_hit)
        wr_tmo_cnt <= wr_tmo_cnt + 1'b1;
      else
        wr_tmo_cnt <= '0;
      if (rd_tmo_hit || wr_tmo_hit)
        tmo_err <= 1'b1;
    end
  end
`else
  assign rd_tmo_hit = 1'b0;
  assign wr_tmo_hit = 1'b0;
  assign tmo_err    = 1'b0;
`endif

endmodule

// File: tb/tb_hawk_cpu_req_gate.sv
// Directed testbench for hawk_cpu_req_gate: read translation, write gating,
// concurrent channels, AR backpressure, reset mid-REQ and the translation
// timeout (identity fallback with HAWK_REQ_TIMEOUT_EN, indefinite wait without).

module tb_hawk_cpu_req_gate;
  import hacd_pkg::*;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               s_ar_valid, s_ar_ready;
  logic [63:0]        s_ar_addr;
  logic [3:0]         s_ar_id;
  logic [7:0]         s_ar_len;
  logic               s_aw_valid, s_aw_ready;
  logic [63:0]        s_aw_addr;
  logic [3:0]         s_aw_id;
  logic [7:0]         s_aw_len;
  logic               s_w_valid, s_w_ready;
  logic [63:0]        s_w_data;
  logic               s_w_last;
  logic               m_ar_valid, m_ar_ready;
  logic [63:0]        m_ar_addr;
  logic [3:0]         m_ar_id;
  logic [7:0]         m_ar_len;
  logic               m_aw_valid, m_aw_ready;
  logic [63:0]        m_aw_addr;
  logic [3:0]         m_aw_id;
  logic [7:0]         m_aw_len;
  logic               m_w_valid, m_w_ready;
  logic [63:0]        m_w_data;
  logic               m_w_last;
  cpu_reqpkt_t        cpu_rd_reqpkt, cpu_wr_reqpkt;
  hawk_cpu_ovrd_pkt_t ovrd_rd, ovrd_wr;
  logic               tmo_err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  hawk_cpu_req_gate #(
    .ADDR_W     (64),
    .PG_OFF_W   (12),
    .ID_W       (4),
    .DATA_W     (64),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .s_ar_valid         (s_ar_valid),
    .s_ar_ready         (s_ar_ready),
    .s_ar_addr          (s_ar_addr),
    .s_ar_id            (s_ar_id),
    .s_ar_len           (s_ar_len),
    .s_aw_valid         (s_aw_valid),
    .s_aw_ready         (s_aw_ready),
    .s_aw_addr          (s_aw_addr),
    .s_aw_id            (s_aw_id),
    .s_aw_len           (s_aw_len),
    .s_w_valid          (s_w_valid),
    .s_w_ready          (s_w_ready),
    .s_w_data           (s_w_data),
    .s_w_last           (s_w_last),
    .m_ar_valid         (m_ar_valid),
    .m_ar_ready         (m_ar_ready),
    .m_ar_addr          (m_ar_addr),
    .m_ar_id            (m_ar_id),
    .m_ar_len           (m_ar_len),
    .m_aw_valid         (m_aw_valid),
    .m_aw_ready         (m_aw_ready),
    .m_aw_addr          (m_aw_addr),
    .m_aw_id            (m_aw_id),
    .m_aw_len           (m_aw_len),
    .m_w_valid          (m_w_valid),
    .m_w_ready          (m_w_ready),
    .m_w_data           (m_w_data),
    .m_w_last           (m_w_last),
    .cpu_rd_reqpkt      (cpu_rd_reqpkt),
    .cpu_wr_reqpkt      (cpu_wr_reqpkt),
    .hawk_cpu_ovrd_rdpkt(ovrd_rd),
    .hawk_cpu_ovrd_wrpkt(ovrd_wr),
    .tmo_err            (tmo_err)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni     = 1'b0;
    s_ar_valid = 1'b0; s_ar_addr = '0; s_ar_id = '0; s_ar_len = '0;
    s_aw_valid = 1'b0; s_aw_addr = '0; s_aw_id = '0; s_aw_len = '0;
    s_w_valid  = 1'b0; s_w_data  = '0; s_w_last = 1'b0;
    m_ar_ready = 1'b1; m_aw_ready = 1'b1; m_w_ready = 1'b1;
    ovrd_rd    = '0;   ovrd_wr    = '0;

    // ------------------------------------------------------------ reset state
    tick(); tick();
    chk("rst_s_ar_ready", 64'(s_ar_ready), 64'd1);
    chk("rst_s_aw_ready", 64'(s_aw_ready), 64'd1);
    chk("rst_s_w_ready",  64'(s_w_ready),  64'd0);
    chk("rst_m_ar_valid", 64'(m_ar_valid), 64'd0);
    chk("rst_m_aw_valid", 64'(m_aw_valid), 64'd0);
    chk("rst_m_w_valid",  64'(m_w_valid),  64'd0);
    chk("rst_m_ar_addr",  m_ar_addr,       64'd0);
    chk("rst_rd_pkt",     64'(cpu_rd_reqpkt), 64'd0);
    chk("rst_wr_pkt",     64'(cpu_wr_reqpkt), 64'd0);
    chk("rst_tmo_err",    64'(tmo_err),    64'd0);
    rst_ni = 1'b1;
    tick();

    // ---------------------------------------------------------- read translate
    s_ar_valid = 1'b1; s_ar_addr = 64'h0000_0000_8000_3A40; s_ar_id = 4'd5; s_ar_len = 8'd3;
    tick();
    s_ar_valid = 1'b0;
    chk("rd_pkt_valid",   64'(cpu_rd_reqpkt.valid), 64'd1);
    chk("rd_pkt_hppa",    64'(cpu_rd_reqpkt.hppa),  64'h80003);
    chk("rd_s_ar_ready",  64'(s_ar_ready), 64'd0);
    tick();
    chk("rd_pkt_stable",  64'(cpu_rd_reqpkt), {11'd0, 1'b1, 52'h80003});
    tick();
    ovrd_rd.allow_access = 1'b1; ovrd_rd.ppa = 52'h12;
    chk("rd_no_early_issue", 64'(m_ar_valid), 64'd0);
    tick();
    ovrd_rd = '0;
    chk("rd_m_ar_valid",  64'(m_ar_valid), 64'd1);
    chk("rd_m_ar_addr",   m_ar_addr,       64'h12A40);
    chk("rd_m_ar_len",    64'(m_ar_len),   64'd3);
    chk("rd_m_ar_id",     64'(m_ar_id),    64'd5);
    chk("rd_pkt_dropped", 64'(cpu_rd_reqpkt.valid), 64'd0);
    tick();
    chk("rd_done_valid",  64'(m_ar_valid), 64'd0);
    chk("rd_done_ready",  64'(s_ar_ready), 64'd1);
    // A grant while IDLE must not retrigger an issue.
    ovrd_rd.allow_access = 1'b1; ovrd_rd.ppa = 52'h55;
    tick();
    ovrd_rd = '0;
    tick();
    chk("rd_idle_grant_ignored", 64'(m_ar_valid), 64'd0);

    // ------------------------------------------------------------ backpressure
    m_ar_ready = 1'b0;
    s_ar_valid = 1'b1; s_ar_addr = 64'h0000_0000_1234_5678; s_ar_id = 4'd1; s_ar_len = 8'd7;
    tick();
    s_ar_valid = 1'b0;
    chk("bp_pkt_hppa", 64'(cpu_rd_reqpkt.hppa), 64'h12345);
    ovrd_rd.allow_access = 1'b1; ovrd_rd.ppa = 52'hABCDE;
    tick();
    ovrd_rd = '0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_m_ar_valid", 64'(m_ar_valid), 64'd1);
      chk("bp_m_ar_addr",  m_ar_addr,       64'hABCDE678);
      chk("bp_s_ar_ready", 64'(s_ar_ready), 64'd0);
      tick();
    end
    m_ar_ready = 1'b1;
    tick();
    chk("bp_done_valid", 64'(m_ar_valid), 64'd0);
    chk("bp_done_ready", 64'(s_ar_ready), 64'd1);

    // ------------------------------------------------------------ write gating
    s_aw_valid = 1'b1; s_aw_addr = 64'h0000_0000_0004_5010; s_aw_id = 4'd2; s_aw_len = 8'd3;
    s_w_valid  = 1'b1; s_w_data = 64'hD000; s_w_last = 1'b0;
    #1;
    chk("wg_pre_s_w_ready", 64'(s_w_ready), 64'd0);
    chk("wg_pre_m_w_valid", 64'(m_w_valid), 64'd0);
    tick();
    s_aw_valid = 1'b0;
    chk("wg_pkt_hppa",     64'(cpu_wr_reqpkt.hppa),  64'h45);
    chk("wg_pkt_valid",    64'(cpu_wr_reqpkt.valid), 64'd1);
    chk("wg_req_s_w_ready", 64'(s_w_ready), 64'd0);
    ovrd_wr.allow_access = 1'b1; ovrd_wr.ppa = 52'h777;
    tick();
    ovrd_wr = '0;
    chk("wg_m_aw_valid",   64'(m_aw_valid), 64'd1);
    chk("wg_m_aw_addr",    m_aw_addr,       64'h777010);
    chk("wg_m_aw_len",     64'(m_aw_len),   64'd3);
    chk("wg_iss_s_w_ready", 64'(s_w_ready), 64'd0);
    tick();
    chk("wg_aw_done",      64'(m_aw_valid), 64'd0);
    chk("wg_open_aw_ready", 64'(s_aw_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      s_w_data = 64'hD000 + 64'(i);
      s_w_last = (i == 3);
      #1;
      chk("wg_beat_s_w_ready", 64'(s_w_ready), 64'd1);
      chk("wg_beat_m_w_valid", 64'(m_w_valid), 64'd1);
      chk("wg_beat_data",      m_w_data,       64'hD000 + 64'(i));
      chk("wg_beat_last",      64'(m_w_last),  (i == 3) ? 64'd1 : 64'd0);
      tick();
    end
    s_w_valid = 1'b0; s_w_last = 1'b0;
    chk("wg_closed_s_w_ready", 64'(s_w_ready), 64'd0);
    chk("wg_closed_aw_ready",  64'(s_aw_ready), 64'd1);

    // -------------------------------------------------------------- concurrent
    s_ar_valid = 1'b1; s_ar_addr = 64'h5000; s_ar_id = 4'd3; s_ar_len = 8'd1;
    s_aw_valid = 1'b1; s_aw_addr = 64'h6ABC; s_aw_id = 4'd4; s_aw_len = 8'd0;
    tick();
    s_ar_valid = 1'b0; s_aw_valid = 1'b0;
    chk("cc_rd_pkt", 64'(cpu_rd_reqpkt), {11'd0, 1'b1, 52'h5});
    chk("cc_wr_pkt", 64'(cpu_wr_reqpkt), {11'd0, 1'b1, 52'h6});
    ovrd_wr.allow_access = 1'b1; ovrd_wr.ppa = 52'h21;
    tick();
    ovrd_wr = '0;
    chk("cc_m_aw_addr",  m_aw_addr,       64'h21ABC);
    chk("cc_m_ar_idle",  64'(m_ar_valid), 64'd0);
    chk("cc_rd_waiting", 64'(cpu_rd_reqpkt.valid), 64'd1);
    tick();
    tick();
    ovrd_rd.allow_access = 1'b1; ovrd_rd.ppa = 52'h31;
    tick();
    ovrd_rd = '0;
    chk("cc_m_ar_valid", 64'(m_ar_valid), 64'd1);
    chk("cc_m_ar_addr",  m_ar_addr,       64'h31000);
    chk("cc_m_ar_id",    64'(m_ar_id),    64'd3);
    tick();
    chk("cc_ar_done", 64'(m_ar_valid), 64'd0);
    s_w_valid = 1'b1; s_w_data = 64'hBEEF; s_w_last = 1'b1;
    #1;
    chk("cc_w_valid", 64'(m_w_valid), 64'd1);
    chk("cc_w_last",  64'(m_w_last),  64'd1);
    tick();
    s_w_valid = 1'b0; s_w_last = 1'b0;
    chk("cc_w_closed",   64'(s_w_ready),  64'd0);
    chk("cc_aw_reopen",  64'(s_aw_ready), 64'd1);

    // ---------------------------------------------------------- reset mid-REQ
    s_ar_valid = 1'b1; s_ar_addr = 64'h9000; s_ar_id = 4'd6; s_ar_len = 8'd0;
    tick();
    s_ar_valid = 1'b0;
    chk("mr_pkt_valid", 64'(cpu_rd_reqpkt.valid), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("mr_rd_pkt",     64'(cpu_rd_reqpkt), 64'd0);
    chk("mr_s_ar_ready", 64'(s_ar_ready),    64'd1);
    chk("mr_m_ar_valid", 64'(m_ar_valid),    64'd0);
    chk("mr_m_ar_addr",  m_ar_addr,          64'd0);
    chk("mr_m_aw_addr",  m_aw_addr,          64'd0);
    chk("mr_m_ar_len",   64'(m_ar_len),      64'd0);
    tick();
    rst_ni = 1'b1;
    ovrd_rd.allow_access = 1'b1; ovrd_rd.ppa = 52'h44;
    tick();
    ovrd_rd = '0;
    tick(); tick();
    chk("mr_no_replay",  64'(m_ar_valid),    64'd0);
    chk("mr_no_pkt",     64'(cpu_rd_reqpkt), 64'd0);

    // ----------------------------------------------------------------- timeout
    s_ar_valid = 1'b1; s_ar_addr = 64'h0000_0000_8000_3A40; s_ar_id = 4'd7; s_ar_len = 8'd2;
    tick();
    s_ar_valid = 1'b0;
`ifdef HAWK_REQ_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      chk("to_pre_tmo_err", 64'(tmo_err),    64'd0);
      chk("to_pre_valid",   64'(m_ar_valid), 64'd0);
      tick();
    end
    chk("to_pre_final", 64'(tmo_err), 64'd0);
    tick();
    chk("to_tmo_err",    64'(tmo_err),    64'd1);
    chk("to_m_ar_valid", 64'(m_ar_valid), 64'd1);
    chk("to_m_ar_addr",  m_ar_addr,       64'h0000_0000_8000_3A40);
    tick();
    tick();
    chk("to_sticky",     64'(tmo_err),    64'd1);
`else
    for (int i = 0; i < 24; i++) tick();
    chk("nt_still_req",  64'(cpu_rd_reqpkt.valid), 64'd1);
    chk("nt_no_issue",   64'(m_ar_valid), 64'd0);
    chk("nt_tmo_err",    64'(tmo_err),    64'd0);
    ovrd_rd.allow_access = 1'b1; ovrd_rd.ppa = 52'h99;
    tick();
    ovrd_rd = '0;
    chk("nt_m_ar_addr",  m_ar_addr,       64'h99A40);
    tick();
    chk("nt_done",       64'(m_ar_valid), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
